imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the core's instruction memory.

---
 rtl/imem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader feeding the instruction-memory write port.
//   It receives framed bytes over a valid/ready link and assembles them into
//   little-endian 32-bit words, which it writes one per strobe.
//   The core is held in reset while a frame is loading. It is released by a
//   RUN command that follows a frame whose checksum was good.
//
//   Frame layout: HDR, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN*4 data bytes, CSUM
//     - LEN counts words.
//     - CSUM is the XOR of all data bytes.
//
// Ports
//   clk       in   1       clock; all state changes on the rising edge
//   rst       in   1       asynchronous reset, active low
//   in_valid  in   1       byte valid from the host link
//   in_data   in   8       byte from the host link
//   in_ready  out  1       loader accepts a byte (transfer = in_valid & in_ready)
//   wr_en     out  1       i_mem write strobe, one cycle per word
//   wr_addr   out  ADDR_W  i_mem byte address, always word aligned
//   wr_data   out  32      {b3,b2,b1,b0}; b0 is the first byte received
//   wr_be     out  4       byte enables, all ones while wr_en is high
//   core_rst  out  1       active-high reset to the core
//   busy      out  1       a frame is in progress
//   done      out  1       the last frame completed with a good checksum
//   err       out  1       sticky: checksum mismatch or address overflow
//   words     out  16      words written by the current/last frame
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [7:0]  HDR     = 8'hA5,
    parameter logic [7:0]  RUN_CMD = 8'h5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words
);

    typedef enum logic [2:0] {
        S_IDLE, S_A0, S_A1, S_L0, S_L1, S_DATA, S_CSUM, S_RUN
    } state_t;

    // Keeps the address inside the memory and forces word alignment.
    localparam logic [15:0] ADDR_MASK = 16'((1 << ADDR_W) - 1) & 16'hFFFC;

    state_t state_reg, state_next;

    logic              in_ready_reg;
    logic              wr_en_reg;
    logic [31:0]       wr_data_reg;
    logic              done_reg;
    logic              err_reg;
    logic [15:0]       words_reg;
    logic [7:0]        addr_lo_reg;
    logic [7:0]        len_lo_reg;
    logic [15:0]       len_left_reg;   // words still expected, including the one being assembled
    logic [1:0]        byte_idx_reg;   // byte position within the current word
    logic [23:0]       word_lo_reg;    // first three bytes of the word, shifted in from the top
    logic [7:0]        csum_reg;
    // Extra top bit is the carry out of the address space. Once it is set,
    // every further word in the frame lies beyond the end of memory.
    logic [ADDR_W:0]   addr_reg;

    logic xfer;
    logic frame_start;
    logic word_done;

    assign xfer        = in_valid & in_ready_reg;
    assign frame_start = xfer && (in_data == HDR) &&
                         ((state_reg == S_IDLE) || (state_reg == S_RUN));
    assign word_done   = xfer && (state_reg == S_DATA) && (byte_idx_reg == 2'd3);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (xfer) begin
                    if (in_data == HDR) begin
                        state_next = S_A0;
                    end else if (in_data == RUN_CMD && done_reg && !err_reg) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_A0:   if (xfer) state_next = S_A1;
            S_A1:   if (xfer) state_next = S_L0;
            S_L0:   if (xfer) state_next = S_L1;
            S_L1: begin
                if (xfer) begin
                    state_next = ({in_data, len_lo_reg} == 16'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: if (word_done && len_left_reg == 16'd1) state_next = S_CSUM;
            S_CSUM: if (xfer) state_next = S_IDLE;
            S_RUN:  if (xfer && in_data == HDR) state_next = S_A0;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_reg <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= 32'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            words_reg    <= 16'd0;
            addr_lo_reg  <= 8'd0;
            len_lo_reg   <= 8'd0;
            len_left_reg <= 16'd0;
            byte_idx_reg <= 2'd0;
            word_lo_reg  <= 24'd0;
            csum_reg     <= 8'd0;
            addr_reg     <= '0;
        end else begin
            // The write cycle takes no byte, so it never overlaps a new transfer.
            in_ready_reg <= !word_done;
            wr_en_reg    <= 1'b0;

            if (wr_en_reg) begin
                addr_reg  <= addr_reg + (ADDR_W+1)'(4);
                words_reg <= words_reg + 16'd1;
            end

            if (frame_start) begin
                err_reg   <= 1'b0;
                done_reg  <= 1'b0;
                words_reg <= 16'd0;
            end

            if (xfer) begin
                case (state_reg)
                    S_A0: addr_lo_reg <= in_data;
                    S_A1: addr_reg    <= (ADDR_W+1)'({in_data, addr_lo_reg} & ADDR_MASK);
                    S_L0: len_lo_reg  <= in_data;
                    S_L1: begin
                        len_left_reg <= {in_data, len_lo_reg};
                        byte_idx_reg <= 2'd0;
                        csum_reg     <= 8'd0;
                    end
                    S_DATA: begin
                        csum_reg     <= csum_reg ^ in_data;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            len_left_reg <= len_left_reg - 16'd1;
                            if (addr_reg[ADDR_W]) begin
                                err_reg <= 1'b1;
                            end else begin
                                wr_en_reg   <= 1'b1;
                                wr_data_reg <= {in_data, word_lo_reg};
                            end
                        end else begin
                            word_lo_reg <= {in_data, word_lo_reg[23:8]};
                        end
                    end
                    S_CSUM: begin
                        if (in_data == csum_reg) begin
                            done_reg <= 1'b1;
                        end else begin
                            err_reg  <= 1'b1;
                            done_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = in_ready_reg;
    assign wr_en    = wr_en_reg;
    assign wr_addr  = addr_reg[ADDR_W-1:0];
    assign wr_data  = wr_data_reg;
    assign wr_be    = {4{wr_en_reg}};
    assign core_rst = (state_reg != S_RUN);
    assign busy     = (state_reg != S_IDLE) && (state_reg != S_RUN);
    assign done     = done_reg;
    assign err      = err_reg;
    assign words    = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed frames drive imem_loader. A frame-level model predicts every
//   output on every cycle. Literal checks after each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .core_rst(core_rst), .busy(busy), .done(done), .err(err),
        .words(words)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit          m_ready, m_wr, m_frame, m_run, m_done, m_err;
    int          m_words, m_idx, m_len, m_base, m_x, m_waddr;
    logic [31:0] m_wdata;
    logic [7:0]  m_b [4];
    logic [7:0]  m_alo, m_llo;

    task automatic model_reset();
        m_ready = 0; m_wr = 0; m_frame = 0; m_run = 0;
        m_done = 0;  m_err = 0; m_words = 0;
    endtask

    // Advance the model across one rising edge; b is the byte transferred, if any.
    task automatic model_step(input bit xfer, input logic [7:0] b);
        int d, a;
        if (m_wr) m_words++;
        m_wr    = 0;
        m_ready = 1;
        if (!xfer) return;
        if (!m_frame) begin
            if (b == 8'hA5) begin
                m_frame = 1; m_idx = 0; m_err = 0; m_done = 0; m_words = 0; m_run = 0;
            end else if (!m_run && b == 8'h5A && m_done && !m_err) begin
                m_run = 1;
            end
            return;
        end
        case (m_idx)
            0: m_alo = b;
            1: m_base = ((int'(b) * 256 + int'(m_alo)) % (1 << ADDR_W)) / 4 * 4;
            2: m_llo = b;
            3: begin m_len = int'(b) * 256 + int'(m_llo); m_x = 0; end
            default: begin
                d = m_idx - 4;
                if (d < 4 * m_len) begin
                    m_x = m_x ^ int'(b);
                    m_b[d % 4] = b;
                    if (d % 4 == 3) begin
                        m_ready = 0;
                        a = m_base + 4 * (d / 4);
                        if (a <= (1 << ADDR_W) - 4) begin
                            m_wr = 1; m_waddr = a;
                            m_wdata = {m_b[3], m_b[2], m_b[1], m_b[0]};
                        end else begin
                            m_err = 1;
                        end
                    end
                end else begin
                    if (int'(b) == m_x) m_done = 1;
                    else begin m_err = 1; m_done = 0; end
                    m_frame = 0;
                end
            end
        endcase
        m_idx++;
    endtask

    // ------------------------------------------------- per-cycle comparison
    logic [31:0] waddr_q[$];
    logic [31:0] wdata_q[$];
    int          ready_low_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
            chk("rst_wr_addr", 32'(wr_addr), 32'd0);
            chk("rst_wr_data", wr_data, 32'd0);
        end
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("wr_en",    32'(wr_en),    32'(m_wr));
        chk("wr_be",    32'(wr_be),    m_wr ? 32'hF : 32'h0);
        chk("core_rst", 32'(core_rst), 32'(!m_run));
        chk("busy",     32'(busy),     32'(m_frame));
        chk("done",     32'(done),     32'(m_done));
        chk("err",      32'(err),      32'(m_err));
        chk("words",    32'(words),    32'(m_words));
        if (m_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_waddr));
            chk("wr_data", wr_data, m_wdata);
        end
        if (wr_en) begin
            waddr_q.push_back(32'(wr_addr));
            wdata_q.push_back(wr_data);
        end
        if (busy && !in_ready) ready_low_cnt++;
        if (rst) model_step(in_valid && m_ready, in_data);
    end

    // ------------------------------------------------------------- drivers
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin in_valid = 0; @(posedge clk); #1; end
        in_valid = 1;
        in_data  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    logic [7:0] t1 [14] = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00,
                            8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00,
                            8'h25};
    logic [7:0] t3 [6]  = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] t4 [14] = '{8'hA5, 8'hFC, 8'h0F, 8'h02, 8'h00,
                            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                            8'h88};

    initial begin
        @(posedge clk); #1;
        idle(2);
        rst = 1;
        idle(2);

        // T1: two-word frame, then RUN
        for (int i = 0; i < 14; i++) send(t1[i], 0);
        idle(2);
        chk("t1_nwr",   32'(waddr_q.size()), 32'd2);
        chk("t1_a0",    waddr_q[0], 32'h000);
        chk("t1_d0",    wdata_q[0], 32'h00500513);
        chk("t1_a1",    waddr_q[1], 32'h004);
        chk("t1_d1",    wdata_q[1], 32'h00100073);
        chk("t1_words", 32'(words), 32'd2);
        chk("t1_done",  32'(done),  32'd1);
        send(8'h5A, 0);
        chk("t1_run",   32'(core_rst), 32'd0);

        // T2: same frame with a bad checksum, RUN refused
        waddr_q.delete(); wdata_q.delete();
        for (int i = 0; i < 13; i++) send(t1[i], 0);
        send(8'h26, 0);
        idle(2);
        chk("t2_err",  32'(err),  32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_nwr",  32'(waddr_q.size()), 32'd2);
        send(8'h5A, 0);
        idle(1);
        chk("t2_core_rst", 32'(core_rst), 32'd1);
        chk("t2_busy",     32'(busy),     32'd0);

        // T3: zero-length frame
        waddr_q.delete(); wdata_q.delete();
        for (int i = 0; i < 6; i++) send(t3[i], 0);
        idle(2);
        chk("t3_nwr",   32'(waddr_q.size()), 32'd0);
        chk("t3_done",  32'(done),  32'd1);
        chk("t3_words", 32'(words), 32'd0);
        chk("t3_err",   32'(err),   32'd0);

        // T4: second word falls off the end of memory
        waddr_q.delete(); wdata_q.delete();
        for (int i = 0; i < 14; i++) send(t4[i], 0);
        idle(2);
        chk("t4_nwr",   32'(waddr_q.size()), 32'd1);
        chk("t4_a0",    waddr_q[0], 32'hFFC);
        chk("t4_d0",    wdata_q[0], 32'h44332211);
        chk("t4_err",   32'(err),   32'd1);
        chk("t4_words", 32'(words), 32'd1);

        // T5: T1 frame with random valid gaps
        waddr_q.delete(); wdata_q.delete();
        ready_low_cnt = 0;
        for (int i = 0; i < 14; i++) send(t1[i], int'($urandom_range(0, 3)));
        idle(2);
        chk("t5_nwr",   32'(waddr_q.size()), 32'd2);
        chk("t5_d0",    wdata_q[0], 32'h00500513);
        chk("t5_d1",    wdata_q[1], 32'h00100073);
        chk("t5_rdy_low", 32'(ready_low_cnt), 32'd2);
        chk("t5_done",  32'(done), 32'd1);

        // T6: reset after the 6th data byte, then a clean reload
        waddr_q.delete(); wdata_q.delete();
        for (int i = 0; i < 11; i++) send(t1[i], 0);
        rst = 0;
        idle(2);
        chk("t6_nwr",      32'(waddr_q.size()), 32'd1);
        chk("t6_a0",       waddr_q[0], 32'h000);
        chk("t6_rdy",      32'(in_ready), 32'd0);
        chk("t6_core_rst", 32'(core_rst), 32'd1);
        rst = 1;
        idle(1);
        for (int i = 0; i < 14; i++) send(t1[i], 0);
        idle(2);
        chk("t6_nwr2", 32'(waddr_q.size()), 32'd3);
        chk("t6_d1",   wdata_q[1], 32'h00500513);
        chk("t6_d2",   wdata_q[2], 32'h00100073);
        send(8'h5A, 0);
        chk("t6_run", 32'(core_rst), 32'd0);
        send(8'h33, 0);
        chk("t6_run_drop", 32'(core_rst), 32'd0);
        send(8'hA5, 0);
        chk("t6_hdr_core_rst", 32'(core_rst), 32'd1);
        chk("t6_hdr_busy",     32'(busy),     32'd1);
        for (int i = 1; i < 14; i++) send(t1[i], 0);
        idle(2);
        chk("t6_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
